// File: rtl/addac_serial_acc.sv
// Bit-serial accumulator: LOAD/ADD/SUB through one full-adder slice, LSB first; CLEAR in one cycle.
// Optional macro ADDAC_OVF_EN adds a signed-overflow output ovf.
module addac_serial_acc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] acc,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef ADDAC_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
`ifdef ADDAC_OVF_EN
    logic             ovf_q;
`endif

    // Single full-adder slice; the working copy sh_q keeps acc untouched until commit.
    logic x_bit, y_bit, sum_bit, carry_nxt, last_bit;
    assign x_bit     = sh_q[0];
    assign y_bit     = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    assign sum_bit   = x_bit ^ y_bit ^ carry_q;
    assign carry_nxt = (x_bit & y_bit) | (carry_q & (x_bit ^ y_bit));
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            acc_q   <= '0;
            sh_q    <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef ADDAC_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        b_q   <= a;
                        cnt_q <= '0;
                        if (op == OP_CLR) begin
                            acc_q   <= '0;
                            cout_q  <= 1'b0;
                            carry_q <= 1'b0;
`ifdef ADDAC_OVF_EN
                            ovf_q   <= 1'b0;
`endif
                            state_q <= DONE;
                        end else begin
                            // LOAD starts from zero so the acc bit is effectively forced 0.
                            sh_q    <= (op == OP_LOAD) ? '0 : acc_q;
                            carry_q <= (op == OP_SUB);
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sh_q    <= {sum_bit, sh_q[WIDTH-1:1]};
                    b_q     <= b_q >> 1;
                    carry_q <= carry_nxt;
                    if (last_bit) begin
                        acc_q   <= {sum_bit, sh_q[WIDTH-1:1]};
                        cout_q  <= (op_q == OP_LOAD) ? 1'b0 : carry_nxt;
`ifdef ADDAC_OVF_EN
                        ovf_q   <= (op_q == OP_LOAD) ? 1'b0 : (carry_q ^ carry_nxt);
`endif
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign acc      = acc_q;
    assign cout     = cout_q;
`ifdef ADDAC_OVF_EN
    assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_addac_serial_acc.sv
// Scoreboard bench for addac_serial_acc (WIDTH=8): directed requests, monitor checks on each done pulse.
module tb_addac_serial_acc;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] acc;
    logic         cout;
    logic         busy;
    logic         done;
`ifdef ADDAC_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] acc;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] hold_acc  = '0;
    logic         hold_cout = 1'b0;
    logic         prev_done = 1'b0;

    addac_serial_acc #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .acc      (acc),
        .cout     (cout),
        .busy     (busy),
        .done     (done)
`ifdef ADDAC_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: pops the expected commit on every done pulse; acc/cout must hold while shifting.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width got 2+ cycles want 1");
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got done=1 want no pulse");
            end else begin
                e = exp_q.pop_front();
                chk("mon_acc", 32'(acc), 32'(e.acc));
                chk("mon_cout", 32'(cout), 32'(e.cout));
`ifdef ADDAC_OVF_EN
                chk("mon_ovf", 32'(ovf), 32'(e.ovf));
`endif
                hold_acc  = e.acc;
                hold_cout = e.cout;
            end
        end else if (busy) begin
            chk("hold_acc", 32'(acc), 32'(hold_acc));
            chk("hold_cout", 32'(cout), 32'(hold_cout));
        end
        prev_done = done;
    end

    // Issue one request, push its expected result, then measure done latency and ready-low time.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] ea,
                         input logic ec, input logic eo, input bit junk);
        int k;
        int done_at;
        int guard;
        int want_lat;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        exp_q.push_back(exp_t'{ea, ec, eo});
        @(posedge clk);
        #1;
        if (junk) begin
            op = 2'b11;
            a  = '1;
        end else begin
            in_valid = 1'b0;
        end
        k       = 0;
        done_at = 0;
        forever begin
            @(negedge clk);
            k++;
            if (done) begin
                done_at  = k;
                in_valid = 1'b0;
            end
            if (in_ready || k >= 50) break;
        end
        want_lat = (o == 2'b11) ? 1 : W + 1;
        chk("done_latency", 32'(done_at), 32'(want_lat));
        chk("ready_low_cycles", 32'(k - 1), 32'(want_lat));
    endtask

    initial begin
        int ndone;
        rst      = 1'b0;
        in_valid = 1'b0;
        op       = 2'b00;
        a        = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_acc", 32'(acc), 32'h00);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
`ifdef ADDAC_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        issue(2'b00, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        issue(2'b10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 8'h01, 8'h11, 1'b0, 1'b0, 1'b1);
        issue(2'b11, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        issue(2'b00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0);

        // Abort an ADD mid-shift with reset at E4.
        issue(2'b00, 8'h44, 8'h44, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b01;
        a        = 8'h33;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        hold_acc  = '0;
        hold_cout = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_acc", 32'(acc), 32'h00);
        chk("abort_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        issue(2'b00, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        issue(2'b10, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        issue(2'b01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        issue(2'b00, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addac_serial_acc.md
ADDAC_SERIAL_ACC -- requirements
Module: addac_serial_acc

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/accumulator width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-007 SHALL have port: a  input  WIDTH  operand.
REQ-008 SHALL have port: acc  output  WIDTH  committed accumulator value.
REQ-009 SHALL have port: cout  output  1  carry out of the last ADD/SUB; 0 after LOAD/CLEAR.
REQ-010 SHALL have port: busy  output  1  operation in progress (state not IDLE).
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; busy = not IDLE.
REQ-013 SHALL accept a request on edge E0 where in_valid & in_ready; SHALL latch op and a on E0; SHALL ignore in_valid at all other times.
REQ-014 LOAD/ADD/SUB SHALL go IDLE->SHIFT on E0, with bit counter 0 and carry initialised to 0 (LOAD, ADD) or 1 (SUB).
REQ-015 In SHIFT, edge E(i+1) SHALL process bit i (LSB first) via one 1-bit full-adder slice and carry flop: LOAD b=a[i] with acc bit forced 0; ADD b=a[i]; SUB b=~a[i].
REQ-016 Edge EW (bit WIDTH-1) SHALL commit the shifted result to acc, commit final carry to cout (forced 0 for LOAD), and enter DONE.
REQ-017 acc and cout SHALL remain stable at their previous committed values throughout SHIFT.
REQ-018 CLEAR SHALL go IDLE->DONE on E0, setting acc=0 and cout=0 on that edge.
REQ-019 done SHALL be 1 for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-020 Latency SHALL be WIDTH+1 cycles accept-to-done for LOAD/ADD/SUB and 1 cycle for CLEAR; throughput one request per WIDTH+2 cycles.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; SUB cout=1 means no borrow (acc >= a unsigned).
REQ-022 Bit counter SHALL be ceil(log2(WIDTH)) bits and SHALL NOT wrap within an operation.

Reset
REQ-023 rst=0 on an edge SHALL force IDLE, acc=0, cout=0, done=0, busy=0, in_ready=1, counter and carry 0, from any state.
REQ-024 A reset during SHIFT SHALL abort the operation without committing any partial result and without a done pulse.

Configuration
REQ-025 Macro ADDAC_OVF_EN defined SHALL add output port ovf (1 bit): on commit of ADD/SUB = carry into MSB XOR carry out of MSB, 0 for LOAD/CLEAR, 0 on reset, held otherwise.
REQ-026 Without ADDAC_OVF_EN, ovf port and its logic SHALL NOT exist; all other behaviour is identical.

Verification (WIDTH=8)
REQ-027 rst=0 for 2 edges then 1 -> acc=0x00, cout=0, done=0, busy=0, in_ready=1.
REQ-028 LOAD a=0xA5 accepted at E0 -> in_ready=0 for 9 cycles, done=1 in cycle after E8, acc=0xA5, cout=0.
REQ-029 acc=0xF0, ADD a=0x20 -> acc=0x10, cout=1; then SUB a=0x20 -> acc=0xF0, cout=0.
REQ-030 in_valid held high with op=CLEAR during SHIFT of ADD 0x01 from acc=0x10 -> ignored; acc=0x11, then CLEAR accepted in IDLE -> acc=0x00 with done one cycle later.
REQ-031 ADD a=0x33 from acc=0x44, rst=0 at edge E4 -> next cycle IDLE, acc=0x00, no done pulse ever for that request.
REQ-032 With ADDAC_OVF_EN: acc=0x7F ADD 0x01 -> acc=0x80, cout=0, ovf=1; then acc=0x80 SUB 0x01 -> acc=0x7F, cout=1, ovf=1.
